// File: rtl/stack_operand_unit_pkg.sv
// Shared definitions for the operand stack: operation encodings and default sizes.
// The multicycle control unit imports the same package so both sides agree on stackOp.
package stack_operand_unit_pkg;

    localparam int STK_WIDTH_DEF = 16;
    localparam int STK_DEPTH_DEF = 16;

    typedef enum logic [1:0] {
        STK_NOP     = 2'b00,
        STK_PUSH    = 2'b01,
        STK_POP     = 2'b10,
        STK_REPLACE = 2'b11
    } stk_op_e;

endpackage : stack_operand_unit_pkg

// File: rtl/stack_operand_unit_storage.sv
// DEPTH x WIDTH register array for the operand stack.
// One synchronous write port and two asynchronous read ports (TOS and NOS).
module stack_operand_unit_storage #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [PTR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [PTR_W-1:0] i_tos_idx,
    input  logic [PTR_W-1:0] i_nos_idx,
    output logic [WIDTH-1:0] o_tos_raw,
    output logic [WIDTH-1:0] o_nos_raw
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port: single entry updated per edge when enabled.
    // NOTE: the array has no reset; validity is tracked by the depth counter in the top level,
    // so clearing contents would only cost a reset net to every flop for no functional gain.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_tos_raw = r_mem[i_tos_idx];
    assign o_nos_raw = r_mem[i_nos_idx];

endmodule : stack_operand_unit_storage

// File: rtl/stack_operand_unit.sv
// Operand stack for the 16-bit stack processor: depth tracking, legality checks,
// sticky overflow/underflow flags and the A/B operand registers feeding the ALU stage.
module stack_operand_unit
    import stack_operand_unit_pkg::*;
#(
    parameter int WIDTH = STK_WIDTH_DEF,
    parameter int DEPTH = STK_DEPTH_DEF,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [1:0]       stackOp,
    input  logic [WIDTH-1:0] wdata,
    input  logic             loadAB,
    input  logic             clrErr,
    output logic [WIDTH-1:0] Avalue,
    output logic [WIDTH-1:0] Bvalue,
    output logic [WIDTH-1:0] tos,
    output logic [PTR_W:0]   depth,
    output logic             empty,
    output logic             full,
    output logic             ovflw_err,
    output logic             undflw_err
);

    localparam logic [PTR_W:0] DEPTH_MAX = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] DEPTH_ONE = (PTR_W+1)'(1);

    logic [PTR_W:0]   r_depth;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_ovflw;
    logic             r_undflw;

    stk_op_e          w_op;
    logic             w_empty;
    logic             w_full;
    logic             w_ge2;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic             w_repl_ok;
    logic             w_ovflw_new;
    logic             w_undflw_new;
    logic [PTR_W-1:0] w_tos_idx;
    logic [PTR_W-1:0] w_nos_idx;
    logic [WIDTH-1:0] w_tos_raw;
    logic [WIDTH-1:0] w_nos_raw;
    logic [WIDTH-1:0] w_tos;
    logic [WIDTH-1:0] w_nos;
    logic             w_we;
    logic [PTR_W-1:0] w_waddr;

    assign w_op    = stk_op_e'(stackOp);
    assign w_empty = (r_depth == '0);
    assign w_full  = (r_depth == DEPTH_MAX);
    assign w_ge2   = (r_depth > DEPTH_ONE);

    // Index arithmetic wraps in PTR_W bits: at depth==DEPTH the low bits are 0, so 0-1 lands on DEPTH-1.
    assign w_tos_idx = r_depth[PTR_W-1:0] - PTR_W'(1);
    assign w_nos_idx = r_depth[PTR_W-1:0] - PTR_W'(2);

    // Legal operations change state; illegal ones only raise a flag.
    assign w_push_ok    = (w_op == STK_PUSH)    && !w_full;
    assign w_pop_ok     = (w_op == STK_POP)     && !w_empty;
    assign w_repl_ok    = (w_op == STK_REPLACE) && w_ge2;
    assign w_ovflw_new  = (w_op == STK_PUSH)    && w_full;
    assign w_undflw_new = ((w_op == STK_POP) && w_empty) || ((w_op == STK_REPLACE) && !w_ge2);

    // Select the single write-port access: PUSH writes above TOS, REPLACE overwrites NOS.
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_depth[PTR_W-1:0];
        if (w_push_ok) begin
            w_we    = 1'b1;
            w_waddr = r_depth[PTR_W-1:0];
        end else if (w_repl_ok) begin
            w_we    = 1'b1;
            w_waddr = w_nos_idx;
        end
    end

    stack_operand_unit_storage #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_storage (
        .i_clk     (CLK),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (wdata),
        .i_tos_idx (w_tos_idx),
        .i_nos_idx (w_nos_idx),
        .o_tos_raw (w_tos_raw),
        .o_nos_raw (w_nos_raw)
    );

    // Entries above depth are stale, so mask them rather than expose old contents.
    assign w_tos = w_empty ? '0 : w_tos_raw;
    assign w_nos = w_ge2   ? w_nos_raw : '0;

    // Depth counter: saturates at 0 and DEPTH because illegal ops never reach it.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_depth <= '0;
        end else if (w_push_ok) begin
            r_depth <= r_depth + DEPTH_ONE;
        end else if (w_pop_ok || w_repl_ok) begin
            r_depth <= r_depth - DEPTH_ONE;
        end
    end

    // Operand capture: A/B take the pre-edge TOS/NOS, independent of that cycle's op.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_a <= '0;
            r_b <= '0;
        end else if (loadAB) begin
            r_a <= w_tos;
            r_b <= w_nos;
        end
    end

    // Sticky error flags: a new error wins over a simultaneous clear.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_ovflw  <= 1'b0;
            r_undflw <= 1'b0;
        end else begin
            if (w_ovflw_new) begin
                r_ovflw <= 1'b1;
            end else if (clrErr) begin
                r_ovflw <= 1'b0;
            end
            if (w_undflw_new) begin
                r_undflw <= 1'b1;
            end else if (clrErr) begin
                r_undflw <= 1'b0;
            end
        end
    end

    assign Avalue     = r_a;
    assign Bvalue     = r_b;
    assign tos        = w_tos;
    assign depth      = r_depth;
    assign empty      = w_empty;
    assign full       = w_full;
    assign ovflw_err  = r_ovflw;
    assign undflw_err = r_undflw;

endmodule : stack_operand_unit
